// File: rtl/ctrl_unit_seq.sv
// Multi-cycle fetch/decode/execute/writeback control unit with PC, IR, register file and ready-handshaked memory port.
// Optional branch-if-zero opcode is enabled by defining CU_BRANCH_EN.
module ctrl_unit_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int OP_W   = 3,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic [2:0]        state_out
);

    localparam int NREGS = 2 ** REG_W;
    localparam logic [OP_W-1:0] OP_STORE = {OP_W{1'b1}};
    localparam logic [OP_W-1:0] OP_LOAD  = OP_STORE - {{(OP_W-1){1'b0}}, 1'b1};
`ifdef CU_BRANCH_EN
    localparam logic [OP_W-1:0] OP_BRZ   = OP_STORE - {{(OP_W-2){1'b0}}, 2'b10};
`endif

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;

    logic [OP_W-1:0]     ir_op_s;
    logic [ADDR_W-1:0]   ir_addr_s;
    logic [REG_W-1:0]    ir_rd_s, ir_rs1_s, ir_rs2_s;

    assign ir_op_s   = ir_q[OP_W-1:0];
    assign ir_addr_s = ir_q[OP_W+ADDR_W-1:OP_W];
    assign ir_rd_s   = ir_q[OP_W+ADDR_W+REG_W-1:OP_W+ADDR_W];
    assign ir_rs1_s  = ir_q[OP_W+REG_W-1:OP_W];
    assign ir_rs2_s  = ir_q[OP_W+2*REG_W-1:OP_W+REG_W];

    // Next-state and datapath update; every field holds unless the current state changes it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        result_d    = result_q;
        regs_d      = regs_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        if (enable) begin
            case (state_q)
                ST_FETCH: begin
                    // Right after reset no request is up yet, so raise it before waiting for ready.
                    if (!mem_rd_q) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = pc_q;
                    end else if (mem_ready) begin
                        ir_d     = mem_rdata;
                        pc_d     = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        mem_rd_d = 1'b0;
                        state_d  = ST_DECODE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (ir_op_s == OP_LOAD) begin
                        mem_addr_d = ir_addr_s;
                        mem_rd_d   = 1'b1;
                        state_d    = ST_MEM;
                    end else if (ir_op_s == OP_STORE) begin
                        mem_addr_d  = ir_addr_s;
                        mem_wdata_d = regs_q[ir_rd_s];
                        mem_wr_d    = 1'b1;
                        state_d     = ST_MEM;
`ifdef CU_BRANCH_EN
                    end else if (ir_op_s == OP_BRZ) begin
                        if (regs_q[ir_rd_s] == {DATA_W{1'b0}}) begin
                            pc_d       = ir_addr_s;
                            mem_addr_d = ir_addr_s;
                        end else begin
                            mem_addr_d = pc_q;
                        end
                        mem_rd_d = 1'b1;
                        state_d  = ST_FETCH;
`endif
                    end else begin
                        alu_op_d = ir_op_s;
                        alu_a_d  = regs_q[ir_rs1_s];
                        alu_b_d  = regs_q[ir_rs2_s];
                        state_d  = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_d = alu_y;
                    state_d  = ST_WB;
                end
                ST_MEM: begin
                    if (!mem_ready) begin
                        state_d = ST_MEM;
                    end else if (mem_rd_q) begin
                        result_d = mem_rdata;
                        mem_rd_d = 1'b0;
                        state_d  = ST_WB;
                    end else begin
                        mem_wr_d   = 1'b0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = ST_FETCH;
                    end
                end
                ST_WB: begin
                    regs_d[ir_rd_s] = result_q;
                    mem_rd_d        = 1'b1;
                    mem_addr_d      = pc_q;
                    state_d         = ST_FETCH;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= {ADDR_W{1'b0}};
            ir_q        <= {DATA_W{1'b0}};
            result_q    <= {DATA_W{1'b0}};
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= {DATA_W{1'b0}};
            alu_op_q    <= {OP_W{1'b0}};
            alu_a_q     <= {DATA_W{1'b0}};
            alu_b_q     <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            result_q    <= result_d;
            regs_q      <= regs_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign pc_out    = pc_q;
    assign ir_out    = ir_q;
    assign state_out = state_q;

endmodule
